// File: rtl/clk_period_measure.sv
// clk_period_measure: measures the high phase, low phase and full period of a
// slow square wave (meas_clk) in inclk cycles, with a valid strobe, a lock flag
// and a stall flag.
// Optional build macro CLK_MEAS_GLITCH_FILTER_EN: a new synchronized level must
// persist for two cycles before it is accepted as an edge.
module clk_period_measure #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        inclk,
  input  logic        Reset,
  input  logic        meas_clk,
  output logic [31:0] high_count,
  output logic [31:0] low_count,
  output logic [31:0] period_count,
  output logic        meas_valid,
  output logic        locked,
  output logic        stalled
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    SYNCING    = 2'd1,
    MEASURE    = 2'd2,
    STALLED    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        s1;
  logic        s2;
  logic        s3;
  logic        edge_acc;
  logic        edge_rise;
  logic        edge_fall;
  logic        timeout_hit;

  logic [31:0] cnt;
  logic [31:0] pend_high;
  logic        have_high;
  logic [32:0] period_sum;

  logic        cap_high;
  logic        commit;
  logic        enter_sync;
  logic        enter_stall;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= meas_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef CLK_MEAS_GLITCH_FILTER_EN
  logic lvl;

  // Accepted level: only changes once s2 and s3 agree on a new value
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      lvl <= 1'b0;
    end else if (edge_acc) begin
      lvl <= s3;
    end
  end

  assign edge_acc  = (s2 == s3) && (s3 != lvl);
  assign edge_rise = edge_acc && s3;
`else
  assign edge_acc  = s2 ^ s3;
  assign edge_rise = edge_acc && s2;
`endif

  assign edge_fall   = edge_acc && !edge_rise;
  // An edge on the compare cycle restarts the count, so it takes priority
  assign timeout_hit = (cnt == TIMEOUT_CYCLES) && !edge_acc;
  assign period_sum  = {1'b0, pend_high} + {1'b0, cnt};
  assign stalled     = (state == STALLED);

  // State register
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      state <= WAIT_FIRST;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_next  = state;
    cap_high    = 1'b0;
    commit      = 1'b0;
    enter_sync  = 1'b0;
    enter_stall = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (edge_acc) begin
          state_next = SYNCING;
          enter_sync = 1'b1;
        end else if (timeout_hit) begin
          state_next  = STALLED;
          enter_stall = 1'b1;
        end
      end
      SYNCING: begin
        if (edge_fall) begin
          cap_high = 1'b1;
        end else if (edge_rise && have_high) begin
          commit     = 1'b1;
          state_next = MEASURE;
        end else if (timeout_hit) begin
          state_next  = STALLED;
          enter_stall = 1'b1;
        end
      end
      MEASURE: begin
        if (edge_fall) begin
          cap_high = 1'b1;
        end else if (edge_rise) begin
          commit = 1'b1;
        end else if (timeout_hit) begin
          state_next  = STALLED;
          enter_stall = 1'b1;
        end
      end
      STALLED: begin
        if (edge_acc) begin
          state_next = SYNCING;
          enter_sync = 1'b1;
        end
      end
      default: begin
        state_next = WAIT_FIRST;
      end
    endcase
  end

  // Saturating phase counter and pending high-phase capture
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      cnt       <= '0;
      pend_high <= '0;
      have_high <= 1'b0;
    end else begin
      if (edge_acc) begin
        cnt <= 32'd1;
      end else if (cnt != '1) begin
        cnt <= cnt + 32'd1;
      end
      if (cap_high) begin
        pend_high <= cnt;
      end
      if (enter_sync) begin
        have_high <= 1'b0;
      end else if (cap_high) begin
        have_high <= 1'b1;
      end
    end
  end

  // Result registers, valid strobe and lock flag
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      high_count   <= '0;
      low_count    <= '0;
      period_count <= '0;
      meas_valid   <= 1'b0;
      locked       <= 1'b0;
    end else begin
      meas_valid <= commit;
      if (commit) begin
        high_count   <= pend_high;
        low_count    <= cnt;
        period_count <= period_sum[32] ? '1 : period_sum[31:0];
        locked       <= (pend_high == high_count) && (cnt == low_count);
      end else if (enter_stall) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_measure.sv
// tb_clk_period_measure: directed vectors for clk_period_measure with
// TIMEOUT_CYCLES = 100; meas_clk is driven on falling inclk edges.
`timescale 1ns/1ps
module tb_clk_period_measure;

`ifdef CLK_MEAS_GLITCH_FILTER_EN
  localparam int LAT       = 4;
  localparam int GL_PULSES = 0;
  localparam int GL_LOW    = 5;
  localparam int GL_LOCK   = 1;
  localparam int EW_HIGH   = 14;
`else
  localparam int LAT       = 3;
  localparam int GL_PULSES = 1;
  localparam int GL_LOW    = 1;
  localparam int GL_LOCK   = 0;
  localparam int EW_HIGH   = 8;
`endif

  logic        inclk    = 1'b0;
  logic        Reset    = 1'b0;
  logic        meas_clk = 1'b0;
  logic [31:0] high_count;
  logic [31:0] low_count;
  logic [31:0] period_count;
  logic        meas_valid;
  logic        locked;
  logic        stalled;

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int pulses     = 0;
  int width_err  = 0;
  int last_pulse = -1;
  int prev_pulse = -1;
  logic valid_q  = 1'b0;

  typedef struct {
    int lo;
    int hi;
    int n;
    int e_hi;
    int e_lo;
    int e_per;
    int e_lock;
    int e_pulses;
  } vec_t;

  vec_t tbl[6];

  clk_period_measure #(.TIMEOUT_CYCLES(32'd100)) dut (
    .inclk        (inclk),
    .Reset        (Reset),
    .meas_clk     (meas_clk),
    .high_count   (high_count),
    .low_count    (low_count),
    .period_count (period_count),
    .meas_valid   (meas_valid),
    .locked       (locked),
    .stalled      (stalled)
  );

  always #5 inclk = ~inclk;

  // Count meas_valid pulses, their cycle stamps and any multi-cycle pulse
  always @(posedge inclk) begin
    cyc = cyc + 1;
    #1;
    if (meas_valid) begin
      pulses     = pulses + 1;
      prev_pulse = last_pulse;
      last_pulse = cyc;
      if (valid_q) width_err = width_err + 1;
    end
    valid_q = meas_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_lvl(input logic lvl, input int len);
    meas_clk = lvl;
    repeat (len) @(negedge inclk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_high"},   high_count,   32'd0);
    check({tag, "_low"},    low_count,    32'd0);
    check({tag, "_period"}, period_count, 32'd0);
    check({tag, "_valid"},  {31'd0, meas_valid}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked},     32'd0);
    check({tag, "_stalled"},{31'd0, stalled},    32'd0);
  endtask

  // Checks the commit made by the entry's last rising edge, LAT cycles later
  task automatic check_entry(input vec_t v, input int idx, input int p0);
    repeat (LAT) @(negedge inclk);
    check($sformatf("e%0d_high", idx),   high_count,   v.e_hi);
    check($sformatf("e%0d_low", idx),    low_count,    v.e_lo);
    check($sformatf("e%0d_period", idx), period_count, v.e_per);
    check($sformatf("e%0d_locked", idx), {31'd0, locked},  v.e_lock);
    check($sformatf("e%0d_stalled", idx),{31'd0, stalled}, 32'd0);
    check($sformatf("e%0d_pulses", idx), pulses - p0, v.e_pulses);
    if (v.e_pulses >= 2)
      check($sformatf("e%0d_spacing", idx), last_pulse - prev_pulse, v.lo + v.hi);
  endtask

  // n periods of (low lo, high hi); results checked after the final rise
  task automatic run_entry(input vec_t v, input int idx);
    int p0;
    p0 = pulses;
    for (int k = 0; k < v.n; k++) begin
      drive_lvl(1'b0, v.lo);
      if (k == v.n - 1) begin
        fork
          check_entry(v, idx, p0);
        join_none
      end
      drive_lvl(1'b1, v.hi);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    //          lo hi n  e_hi e_lo e_per lock pulses
    tbl[0] = '{5, 5, 4, 5,   5,   10,   1,   3};
    tbl[1] = '{7, 3, 3, 3,   7,   10,   1,   3};
    tbl[2] = '{7, 4, 2, 4,   7,   11,   0,   2};
    tbl[3] = '{7, 4, 1, 4,   7,   11,   1,   1};
    tbl[4] = '{2, 5, 2, 5,   2,   7,    0,   2};
    tbl[5] = '{2, 5, 1, 5,   2,   7,    1,   1};

    repeat (3) @(negedge inclk);
    check_outputs_zero("reset");
    Reset = 1'b1;

    for (int i = 0; i < 6; i++) run_entry(tbl[i], i);

    // Hold low after locking: stall 100 cycles after the accepted falling edge
    p = pulses;
    drive_lvl(1'b0, LAT + 99);
    check("stall_early",  {31'd0, stalled}, 32'd0);
    check("stall_early_lock", {31'd0, locked}, 32'd1);
    @(negedge inclk);
    check("stall_flag",   {31'd0, stalled}, 32'd1);
    check("stall_lock",   {31'd0, locked},  32'd0);
    check("stall_high",   high_count,   32'd5);
    check("stall_low",    low_count,    32'd2);
    check("stall_period", period_count, 32'd7);
    check("stall_pulses", pulses - p,   32'd0);

    // Resume: first partial phase discarded, then one full period commits
    p = pulses;
    drive_lvl(1'b1, 5);
    check("resume_stalled", {31'd0, stalled}, 32'd0);
    check("resume_pulses0", pulses - p, 32'd0);
    drive_lvl(1'b0, 5);
    check("resume_pulses1", pulses - p, 32'd0);
    check("resume_hold",    low_count,  32'd2);
    drive_lvl(1'b1, 5);
    check("resume_pulses2", pulses - p, 32'd1);
    check("resume_high",    high_count, 32'd5);
    check("resume_low",     low_count,  32'd5);
    check("resume_lock",    {31'd0, locked}, 32'd0);

    // Asynchronous reset in the middle of a low phase
    drive_lvl(1'b0, 2);
    Reset = 1'b0;
    #2;
    check_outputs_zero("rst_async");
    @(negedge inclk);
    Reset = 1'b1;
    p = pulses;
    drive_lvl(1'b0, 3);
    drive_lvl(1'b1, 5);
    check("rst_pulses0", pulses - p, 32'd0);
    drive_lvl(1'b0, 5);
    check("rst_pulses1", pulses - p, 32'd0);
    check("rst_high0",   high_count, 32'd0);
    drive_lvl(1'b1, 5);
    check("rst_pulses2", pulses - p, 32'd1);
    check("rst_high",    high_count,   32'd5);
    check("rst_low",     low_count,    32'd5);
    check("rst_period",  period_count, 32'd10);
    check("rst_lock",    {31'd0, locked}, 32'd0);

    // One-cycle low glitch on a stable high level
    drive_lvl(1'b0, 5);
    drive_lvl(1'b1, 5);
    check("pre_glitch_lock", {31'd0, locked}, 32'd1);
    p = pulses;
    drive_lvl(1'b0, 1);
    drive_lvl(1'b1, 8);
    check("glitch_pulses", pulses - p, GL_PULSES);
    check("glitch_high",   high_count, 32'd5);
    check("glitch_low",    low_count,  GL_LOW);
    check("glitch_lock",   {31'd0, locked}, GL_LOCK);

    // Low phase of exactly TIMEOUT_CYCLES: the edge on the compare cycle wins
    p = pulses;
    drive_lvl(1'b0, 100);
    drive_lvl(1'b1, 6);
    check("edgewin_stalled", {31'd0, stalled}, 32'd0);
    check("edgewin_pulses",  pulses - p,   32'd1);
    check("edgewin_low",     low_count,    32'd100);
    check("edgewin_high",    high_count,   EW_HIGH);
    check("edgewin_period",  period_count, EW_HIGH + 100);

    check("valid_width", width_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
